// File: rtl/lsu_pipe.sv
// rtl/lsu_pipe.sv - pipelined RV32I load/store unit for one VLIW memory slot
module lsu_pipe #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_we,
  output logic [XLEN/8-1:0] mem_req_be,
  output logic [XLEN-1:0]   mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              exc_valid,
  output logic              exc_misalign,
  output logic [XLEN-1:0]   exc_addr,
  output logic              busy
);
  localparam int PW = $clog2(QDEPTH);
  localparam int NB = XLEN / 8;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_load, is_store, legal, zext_d;
  logic [1:0]      size_d;
  logic [XLEN-1:0] imm, ea;
  logic [1:0]      off;
  logic            misalign;
  logic [NB-1:0]   be_d;
  logic [XLEN-1:0] wdata_d;
  logic            unused_rs1_idx;

  assign opcode         = in_inst[6:0];
  assign funct3         = in_inst[14:12];
  assign is_load        = (opcode == OP_LOAD);
  assign is_store       = (opcode == OP_STORE);
  assign unused_rs1_idx = ^in_inst[19:15];

  always_comb begin
    legal  = 1'b0;
    size_d = SZ_W;
    zext_d = 1'b0;
    if (is_load) begin
      case (funct3)
        3'd0: begin legal = 1'b1; size_d = SZ_B; end
        3'd1: begin legal = 1'b1; size_d = SZ_H; end
        3'd2: begin legal = 1'b1; size_d = SZ_W; end
        3'd4: begin legal = 1'b1; size_d = SZ_B; zext_d = 1'b1; end
        3'd5: begin legal = 1'b1; size_d = SZ_H; zext_d = 1'b1; end
        default: legal = 1'b0;
      endcase
    end else if (is_store) begin
      case (funct3)
        3'd0: begin legal = 1'b1; size_d = SZ_B; end
        3'd1: begin legal = 1'b1; size_d = SZ_H; end
        3'd2: begin legal = 1'b1; size_d = SZ_W; end
        default: legal = 1'b0;
      endcase
    end
  end

  assign imm = is_store ? {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]}
                        : {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign ea  = in_rs1_val + imm;
  assign off = ea[1:0];
  assign misalign = ((size_d == SZ_H) && off[0]) || ((size_d == SZ_W) && (off != 2'd0));

  // Store data is replicated across every lane so the byte enables alone pick the target bytes.
  always_comb begin
    case (size_d)
      SZ_B: begin
        be_d    = NB'(1) << off;
        wdata_d = {NB{in_rs2_val[7:0]}};
      end
      SZ_H: begin
        be_d    = NB'(3) << off;
        wdata_d = {(NB/2){in_rs2_val[15:0]}};
      end
      default: begin
        be_d    = '1;
        wdata_d = in_rs2_val;
      end
    endcase
  end

  logic [PW:0]   count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    q_rd   [QDEPTH];
  logic [1:0]    q_size [QDEPTH];
  logic          q_zext [QDEPTH];
  logic [1:0]    q_off  [QDEPTH];
  logic          is_nop, accept, issue, raise, push, pop;

  assign in_ready = (!mem_req_valid || mem_req_ready) && (count < (PW+1)'(QDEPTH));
  assign is_nop   = (in_inst == 32'd0);
  assign accept   = in_valid && in_ready;
  assign issue    = accept && !is_nop && legal && !misalign;
  assign raise    = accept && !is_nop && (!legal || misalign);
  assign push     = issue && is_load;
  assign pop      = mem_rsp_valid && (count != '0);
  assign busy     = mem_req_valid || (count != '0);

  logic [XLEN-1:0] rsp_shift, rsp_ext;
  assign rsp_shift = mem_rsp_rdata >> {q_off[rd_ptr], 3'b000};

  always_comb begin
    case (q_size[rd_ptr])
      SZ_B: rsp_ext = q_zext[rd_ptr] ? {{(XLEN-8){1'b0}}, rsp_shift[7:0]}
                                     : {{(XLEN-8){rsp_shift[7]}}, rsp_shift[7:0]};
      SZ_H: rsp_ext = q_zext[rd_ptr] ? {{(XLEN-16){1'b0}}, rsp_shift[15:0]}
                                     : {{(XLEN-16){rsp_shift[15]}}, rsp_shift[15:0]};
      default: rsp_ext = rsp_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= in_inst[11:7];
      q_size[wr_ptr] <= size_d;
      q_zext[wr_ptr] <= zext_d;
      q_off[wr_ptr]  <= off;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_we    <= 1'b0;
      mem_req_be    <= '0;
      mem_req_wdata <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= '0;
      exc_valid     <= 1'b0;
      exc_misalign  <= 1'b0;
      exc_addr      <= '0;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else begin
      // A new issue overrides the handshake clear so back-to-back requests flow at one per cycle.
      if (issue) begin
        mem_req_valid <= 1'b1;
        mem_req_addr  <= {ea[XLEN-1:2], 2'b00};
        mem_req_we    <= is_store;
        mem_req_be    <= be_d;
        mem_req_wdata <= wdata_d;
      end else if (mem_req_valid && mem_req_ready) begin
        mem_req_valid <= 1'b0;
      end

      exc_valid    <= raise;
      exc_misalign <= raise && legal;
      exc_addr     <= (raise && legal) ? ea : '0;

      wb_valid <= pop && (q_rd[rd_ptr] != 5'd0);
      if (pop) begin
        wb_rd   <= q_rd[rd_ptr];
        wb_data <= rsp_ext;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_pipe.sv
// tb/tb_lsu_pipe.sv - randomized model-checked bench for lsu_pipe
module tb_lsu_pipe;
  localparam int QDEPTH = 4;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_inst, in_rs1_val, in_rs2_val;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid, exc_misalign;
  logic [31:0] exc_addr;
  logic        busy;

  lsu_pipe #(.XLEN(32), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_be(mem_req_be),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_misalign(exc_misalign), .exc_addr(exc_addr),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { int rd; int nb; bit zext; int off; } ld_t;
  ld_t         q[$];
  int          owed;
  bit          m_req_v, m_req_we;
  logic [31:0] m_req_addr, m_req_wdata;
  logic [3:0]  m_req_be;
  bit          m_wb_v, m_exc_v, m_exc_mis;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_data, m_exc_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_i(input logic [2:0] f3, input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd1, f3, rd, 7'h03};
  endfunction

  function automatic logic [31:0] st_i(input logic [2:0] f3, input logic [11:0] imm);
    return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'h23};
  endfunction

  task automatic model_reset();
    q.delete();
    owed = 0; m_req_v = 0; m_req_we = 0; m_req_addr = 0; m_req_wdata = 0; m_req_be = 0;
    m_wb_v = 0; m_wb_rd = 0; m_wb_data = 0; m_exc_v = 0; m_exc_mis = 0; m_exc_addr = 0;
  endtask

  task automatic idle();
    in_valid = 0; in_inst = 0; mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_rdata = 0;
  endtask

  // Compare DUT against the model, then step the model by the inputs applied this cycle.
  task automatic cycle();
    bit rdy, hs, acc, ld, st;
    ld_t e;
    int nb, f3, tmp;
    logic [31:0] imm, ea, v, mask;
    #1;
    rdy = (!m_req_v || mem_req_ready) && (q.size() < QDEPTH);
    chk("in_ready", in_ready, rdy);
    chk("busy", busy, m_req_v || q.size() != 0);
    chk("req_valid", mem_req_valid, m_req_v);
    if (m_req_v) begin
      chk("req_addr", mem_req_addr, m_req_addr);
      chk("req_we", mem_req_we, m_req_we);
      chk("req_be", mem_req_be, m_req_be);
      chk("req_wdata", mem_req_wdata, m_req_wdata);
    end
    chk("wb_valid", wb_valid, m_wb_v);
    if (m_wb_v) begin
      chk("wb_rd", wb_rd, m_wb_rd);
      chk("wb_data", wb_data, m_wb_data);
    end
    chk("exc_valid", exc_valid, m_exc_v);
    if (m_exc_v) begin
      chk("exc_misalign", exc_misalign, m_exc_mis);
      chk("exc_addr", exc_addr, m_exc_addr);
    end

    hs  = m_req_v && mem_req_ready;
    acc = in_valid && rdy;
    m_wb_v = 0; m_exc_v = 0; m_exc_mis = 0; m_exc_addr = 0;
    if (mem_rsp_valid && owed > 0) owed--;
    if (mem_rsp_valid && q.size() > 0) begin
      e = q.pop_front();
      v = mem_rsp_rdata >> (8 * e.off);
      if (e.nb < 4) begin
        mask = (32'd1 << (8 * e.nb)) - 32'd1;
        v = v & mask;
        if (!e.zext && v[8*e.nb-1]) v = v | ~mask;
      end
      if (e.rd != 0) begin m_wb_v = 1; m_wb_rd = 5'(e.rd); m_wb_data = v; end
    end
    if (hs) begin
      if (!m_req_we) owed++;
      m_req_v = 0;
    end
    if (acc && in_inst != 0) begin
      ld = (in_inst[6:0] == 7'h03);
      st = (in_inst[6:0] == 7'h23);
      f3 = int'(in_inst[14:12]);
      nb = 0;
      if (ld && (f3 == 0 || f3 == 4)) nb = 1;
      else if (ld && (f3 == 1 || f3 == 5)) nb = 2;
      else if (ld && f3 == 2) nb = 4;
      else if (st && f3 < 3) nb = 1 << f3;
      if (nb == 0) begin
        m_exc_v = 1;
      end else begin
        imm = ld ? {{20{in_inst[31]}}, in_inst[31:20]} : {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        ea = in_rs1_val + imm;
        if (ea % nb != 0) begin
          m_exc_v = 1; m_exc_mis = 1; m_exc_addr = ea;
        end else begin
          m_req_v = 1; m_req_we = st; m_req_addr = ea & ~32'd3;
          tmp = ((1 << nb) - 1) << ea[1:0];
          m_req_be = tmp[3:0];
          m_req_wdata = (nb == 1) ? in_rs2_val[7:0] * 32'h01010101 :
                        (nb == 2) ? in_rs2_val[15:0] * 32'h00010001 : in_rs2_val;
          if (ld) q.push_back('{int'(in_inst[11:7]), nb, f3 >= 4, int'(ea[1:0])});
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; idle();
    #1;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (owed > 0 || m_req_v || q.size() > 0); i++) begin
      idle();
      mem_rsp_valid = (owed > 0);
      mem_rsp_rdata = $urandom;
      cycle();
    end
    idle();
    cycle();
    chk("drain_busy", busy, 0);
  endtask

  task automatic load_one(input string nm, input logic [31:0] inst, input logic [31:0] rs1,
                          input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] data);
    idle(); in_valid = 1; in_inst = inst; in_rs1_val = rs1; mem_req_ready = 0;
    cycle();
    chk({nm, "_be"}, mem_req_be, be);
    idle(); cycle();
    mem_rsp_valid = 1; mem_rsp_rdata = rdata;
    cycle();
    chk({nm, "_wb_valid"}, wb_valid, 1);
    chk({nm, "_wb_data"}, wb_data, data);
  endtask

  function automatic logic [31:0] rand_inst();
    int r, tbl[5];
    logic [31:0] t;
    logic [11:0] imm;
    logic [4:0]  rd;
    tbl = '{0, 1, 2, 4, 5};
    r = $urandom_range(0, 19);
    imm = 12'($urandom);
    if ($urandom_range(0, 1) == 1) imm[1:0] = 2'b00;
    rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    if (r == 0) return 32'd0;
    if (r == 1) begin t = $urandom; t[6:0] = 7'h33; return t; end
    if (r == 2) return ld_i(($urandom_range(0, 1) == 1) ? 3'd3 : 3'd6, rd, imm);
    if (r < 12) return ld_i(3'(tbl[$urandom_range(0, 4)]), rd, imm);
    return st_i(3'($urandom_range(0, 2)), imm);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; idle(); in_rs1_val = 0; in_rs2_val = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_exc_valid", exc_valid, 0);

    // LW x5,8(x1)
    idle(); in_valid = 1; in_inst = ld_i(3'd2, 5'd5, 12'd8); in_rs1_val = 32'h100; mem_req_ready = 0;
    cycle();
    chk("t1_req_addr", mem_req_addr, 32'h108);
    chk("t1_req_be", mem_req_be, 4'hf);
    chk("t1_req_we", mem_req_we, 0);
    idle(); cycle();
    mem_rsp_valid = 1; mem_rsp_rdata = 32'hDEADBEEF;
    cycle();
    chk("t1_wb_valid", wb_valid, 1);
    chk("t1_wb_rd", wb_rd, 5);
    chk("t1_wb_data", wb_data, 32'hDEADBEEF);

    load_one("t2_lb", ld_i(3'd0, 5'd6, 12'd0), 32'h203, 32'h80FF7F01, 4'b1000, 32'hFFFFFF80);
    load_one("t2_lbu", ld_i(3'd4, 5'd6, 12'd0), 32'h203, 32'h80FF7F01, 4'b1000, 32'h00000080);

    // SH at 0x102
    idle(); in_valid = 1; in_inst = st_i(3'd1, 12'd0); in_rs1_val = 32'h102; in_rs2_val = 32'h1234ABCD;
    mem_req_ready = 0;
    cycle();
    chk("t3_addr", mem_req_addr, 32'h100);
    chk("t3_be", mem_req_be, 4'b1100);
    chk("t3_wdata", mem_req_wdata, 32'hABCDABCD);
    chk("t3_we", mem_req_we, 1);
    idle(); cycle(); cycle();
    chk("t3_no_wb", wb_valid, 0);

    idle(); in_valid = 1; in_inst = ld_i(3'd2, 5'd7, 12'd0); in_rs1_val = 32'h101;
    cycle();
    chk("t4_exc_valid", exc_valid, 1);
    chk("t4_exc_mis", exc_misalign, 1);
    chk("t4_exc_addr", exc_addr, 32'h101);
    chk("t4_no_req", mem_req_valid, 0);
    in_inst = 32'h00000033;
    cycle();
    chk("t4_illegal_exc", exc_valid, 1);
    chk("t4_illegal_mis", exc_misalign, 0);
    idle(); mem_rsp_valid = 1; mem_rsp_rdata = 32'h12345678;
    cycle();
    chk("spurious_rsp_wb", wb_valid, 0);

    // Fill the load queue with responses held off
    for (int i = 0; i < 4; i++) begin
      idle(); in_valid = 1; in_inst = ld_i(3'd2, 5'(i + 1), 12'(4 * i)); in_rs1_val = 32'h400;
      cycle();
    end
    chk("t5_full_in_ready", in_ready, 0);
    cycle();
    mem_rsp_valid = 1; mem_rsp_rdata = $urandom;
    cycle();
    chk("t5_after_pop_ready", in_ready, 1);
    mem_rsp_valid = 1; mem_rsp_rdata = $urandom;
    cycle();
    chk("t5_push_pop_ready", in_ready, 1);
    mem_rsp_valid = 0;
    cycle();
    chk("t5_refull_ready", in_ready, 0);
    drain();

    idle(); in_valid = 1; in_inst = st_i(3'd2, 12'd0); in_rs1_val = 32'h40; in_rs2_val = 32'hCAFEF00D;
    cycle();
    idle(); mem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_addr", mem_req_addr, 32'h40);
      chk("hold_be", mem_req_be, 4'hf);
      chk("hold_wdata", mem_req_wdata, 32'hCAFEF00D);
    end
    drain();

    // Reset with two loads outstanding and a request held
    idle(); in_valid = 1; in_inst = ld_i(3'd2, 5'd3, 12'd0); in_rs1_val = 32'h80;
    cycle(); cycle();
    mem_req_ready = 0;
    cycle();
    do_reset();
    idle(); mem_rsp_valid = 1; mem_rsp_rdata = 32'hFFFFFFFF;
    cycle();
    chk("t6_late_rsp_wb", wb_valid, 0);
    idle(); cycle();

    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_inst = rand_inst();
      in_rs1_val = $urandom;
      if ($urandom_range(0, 1) == 1) in_rs1_val[1:0] = 2'b00;
      in_rs2_val = $urandom;
      mem_req_ready = ($urandom_range(0, 9) < 7);
      if (owed > 0) mem_rsp_valid = ($urandom_range(0, 1) == 1);
      else mem_rsp_valid = (q.size() == 0) && ($urandom_range(0, 7) == 0);
      mem_rsp_rdata = $urandom;
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
